// File: rtl/pq_keccak_pkg.sv
// Shared types and defaults for the Keccak-f[1600] sequencing logic in the PQ accelerator.
package pq_keccak_pkg;

   localparam int unsigned KECCAK_NUM_ROUNDS = 24;
   localparam int unsigned KECCAK_ROUND_W    = 5;

   typedef enum logic [1:0] {KS_IDLE, KS_RUN, KS_DONE} keccak_seq_state_e;

endpackage

// File: rtl/pq_keccak_round_seq.sv
// Round sequencer for the Keccak-f[1600] datapath: one start pulse runs a full permutation,
// issuing one round write per unstalled cycle and holding the ID stage until done.
module pq_keccak_round_seq
   import pq_keccak_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = KECCAK_NUM_ROUNDS,
   parameter int unsigned ROUND_W    = KECCAK_ROUND_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               keccak_start_i,
   input  logic               stall_i,
   input  logic               abort_i,
   output logic               keccak_f_start_o,
   output logic [ROUND_W-1:0] keccak_round_o,
   output logic               keccak_rst_o,
   output logic               busy_o,
   output logic               done_o
);

   // Compare in ROUND_W bits so NUM_ROUNDS == 2**ROUND_W still terminates correctly.
   localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

   if (NUM_ROUNDS < 1 || NUM_ROUNDS > (1 << ROUND_W)) begin : g_bad_num_rounds
      $error("pq_keccak_round_seq: NUM_ROUNDS must lie in 1..2**ROUND_W");
   end

   keccak_seq_state_e  state_q;
   logic [ROUND_W-1:0] cnt_q;
   logic               in_run;
   logic               advance;

   assign in_run  = (state_q == KS_RUN);
   assign advance = in_run & ~stall_i & ~abort_i;

   assign keccak_f_start_o = advance;
   assign keccak_rst_o     = advance & (cnt_q == '0);
   assign keccak_round_o   = in_run ? cnt_q : '0;
   assign busy_o           = (state_q != KS_IDLE);
   assign done_o           = (state_q == KS_DONE) & ~abort_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= KS_IDLE;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            KS_IDLE: begin
               if (keccak_start_i && !abort_i) begin
                  state_q <= KS_RUN;
                  cnt_q   <= '0;
               end
            end
            KS_RUN: begin
               // Abort beats stall, stall beats progress.
               if (abort_i) begin
                  state_q <= KS_IDLE;
                  cnt_q   <= '0;
               end else if (!stall_i) begin
                  if (cnt_q == LAST_ROUND) begin
                     state_q <= KS_DONE;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + ROUND_W'(1);
                  end
               end
            end
            KS_DONE: begin
               state_q <= KS_IDLE;
               cnt_q   <= '0;
            end
            default: begin
               state_q <= KS_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule
